// File: rtl/serial_ripple_subtractor_if.sv
// Start/busy/done bus for the bit-serial subtractor.
//   start : request, sampled by the subtractor only while idle
//   a, b  : minuend / subtrahend, captured with an accepted start
//   bi    : borrow-in, captured with an accepted start
//   busy  : high while bits are being processed
//   done  : one-cycle pulse when d/bo take a new result
//   d, bo : difference and borrow-out, held between results
// master drives the request side, slave is the subtractor.
interface serial_ripple_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;

  modport master (
    output start, a, b, bi,
    input  busy, done, d, bo
  );

  modport slave (
    input  start, a, b, bi,
    output busy, done, d, bo
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: d = a - b - bi (mod 2^WIDTH), bo = borrow-out.
// One bit is processed per clock, LSB first, through a registered
// full-subtractor cell.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : slave side of serial_ripple_subtractor_if (start/a/b/bi in,
//         busy/done/d/bo out)
module serial_ripple_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  serial_ripple_subtractor_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Working result; d_q only changes on the completing edge so the
  // previous result stays visible during RUN.
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;

  logic             ai, bj, diff, brw_next;
  logic [WIDTH-1:0] work_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      work_q  <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    d_d     = d_q;
    bo_d    = bo_q;

    // Full-subtractor cell on the operand LSBs.
    ai       = a_q[0];
    bj       = b_q[0];
    diff     = ai ^ bj ^ brw_q;
    brw_next = (~ai & bj) | (~(ai ^ bj) & brw_q);

    // Difference bit enters at the MSB; after WIDTH shifts bit 0 is at the LSB.
    work_shift            = work_q >> 1;
    work_shift[WIDTH-1]   = diff;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = bus.bi;
          cnt_d   = '0;
          work_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        brw_d  = brw_next;
        work_d = work_shift;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          d_d     = work_shift;
          bo_d    = brw_next;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.d    = d_q;
  assign bus.bo   = bo_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed testbench for serial_ripple_subtractor (WIDTH=4 and WIDTH=1).
module tb_serial_ripple_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_ripple_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_ripple_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_ripple_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4.slave)
  );

  serial_ripple_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Advance past the next rising edge; sampling/driving happens 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start on the WIDTH=4 instance and wait (bounded) for done.
  // lat = cycle index of done relative to the accept edge, -1 on timeout.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                       output int lat);
    bus4.a     = a;
    bus4.b     = b;
    bus4.bi    = bi;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (bus4.done === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bi = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bi = 1'b0;
    tick();
    tick();
    n_checks++; if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy4 got %b want 0", bus4.busy); end
    n_checks++; if (bus4.done !== 1'b0) begin n_fail++; $display("FAIL reset_done4 got %b want 0", bus4.done); end
    n_checks++; if (bus4.d !== 4'b0000) begin n_fail++; $display("FAIL reset_d4 got %b want 0000", bus4.d); end
    n_checks++; if (bus4.bo !== 1'b0) begin n_fail++; $display("FAIL reset_bo4 got %b want 0", bus4.bo); end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b want 0", bus1.busy); end
    n_checks++; if (bus1.done !== 1'b0) begin n_fail++; $display("FAIL reset_done1 got %b want 0", bus1.done); end
    n_checks++; if (bus1.d !== 1'b0) begin n_fail++; $display("FAIL reset_d1 got %b want 0", bus1.d); end
    n_checks++; if (bus1.bo !== 1'b0) begin n_fail++; $display("FAIL reset_bo1 got %b want 0", bus1.bo); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus4.a = 4'b1010; bus4.b = 4'b1001; bus4.bi = 1'b0; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (bus4.busy !== 1'b1 || bus4.done !== 1'b0 || bus4.d !== 4'b0000) begin
        n_fail++;
        $display("FAIL basic_run cycle %0d got busy=%b done=%b d=%b want busy=1 done=0 d=0000",
                 k, bus4.busy, bus4.done, bus4.d);
      end
      tick();
    end
    n_checks++; if (bus4.done !== 1'b1 || bus4.busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%b busy=%b want 1/0", bus4.done, bus4.busy); end
    n_checks++; if (bus4.d !== 4'b0001) begin n_fail++; $display("FAIL basic_d got %b want 0001", bus4.d); end
    n_checks++; if (bus4.bo !== 1'b0) begin n_fail++; $display("FAIL basic_bo got %b want 0", bus4.bo); end
    tick();
    n_checks++; if (bus4.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", bus4.done); end
  endtask

  task automatic test_underflow();
    int lat;
    do_op(4'b1000, 4'b1111, 1'b0, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL uflow1_latency got %0d want 5", lat); end
    n_checks++; if (bus4.d !== 4'b1001 || bus4.bo !== 1'b1) begin n_fail++; $display("FAIL uflow1_result got d=%b bo=%b want 1001/1", bus4.d, bus4.bo); end
    tick();
    do_op(4'b0000, 4'b0000, 1'b1, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL uflow2_latency got %0d want 5", lat); end
    n_checks++; if (bus4.d !== 4'b1111 || bus4.bo !== 1'b1) begin n_fail++; $display("FAIL uflow2_result got d=%b bo=%b want 1111/1", bus4.d, bus4.bo); end
    tick();
  endtask

  task automatic test_hold_ignore();
    int dones = 0;
    // 0110 - 0011 - 1 = 0010, no borrow
    bus4.a = 4'b0110; bus4.b = 4'b0011; bus4.bi = 1'b1; bus4.start = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      bus4.start = k[0];
      bus4.a     = 4'($urandom);
      bus4.b     = 4'($urandom);
      bus4.bi    = 1'($urandom);
      if (bus4.done === 1'b1) dones++;
      if (k == 5) begin
        n_checks++;
        if (bus4.done !== 1'b1 || bus4.d !== 4'b0010 || bus4.bo !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_result got done=%b d=%b bo=%b want 1/0010/0", bus4.done, bus4.d, bus4.bo);
        end
      end
      tick();
    end
    bus4.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus4.done === 1'b1) dones++;
      n_checks++;
      if (bus4.d !== 4'b0010 || bus4.bo !== 1'b0 || bus4.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_idle cycle %0d got d=%b bo=%b busy=%b want 0010/0/0", k, bus4.d, bus4.bo, bus4.busy);
      end
      tick();
    end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL hold_done_count got %0d want 1", dones); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int dones = 0;
    bus4.a = 4'b1111; bus4.b = 4'b0001; bus4.bi = 1'b0; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    tick();
    rst = 1'b1;  // sampled on RUN edge 2
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.d !== 4'b0000 || bus4.bo !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state got busy=%b done=%b d=%b bo=%b want 0/0/0000/0",
               bus4.busy, bus4.done, bus4.d, bus4.bo);
    end
    for (int k = 0; k < 8; k++) begin
      if (bus4.done === 1'b1 || bus4.busy === 1'b1) dones++;
      tick();
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d active cycles want 0", dones); end
    do_op(4'b1111, 4'b0001, 1'b0, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rstmid_fresh_latency got %0d want 5", lat); end
    n_checks++; if (bus4.d !== 4'b1110 || bus4.bo !== 1'b0) begin n_fail++; $display("FAIL rstmid_fresh_result got d=%b bo=%b want 1110/0", bus4.d, bus4.bo); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat = -1;
    bus4.a = 4'b0101; bus4.b = 4'b0011; bus4.bi = 1'b0; bus4.start = 1'b1;
    tick();
    // Second operands presented immediately; must not disturb the first op.
    bus4.a = 4'b0011; bus4.b = 4'b0101;
    for (int c = 1; c <= 20; c++) begin
      if (bus4.done === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 5", lat); end
    n_checks++; if (bus4.d !== 4'b0010 || bus4.bo !== 1'b0) begin n_fail++; $display("FAIL b2b_first_result got d=%b bo=%b want 0010/0", bus4.d, bus4.bo); end
    tick();
    n_checks++; if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got busy=%b done=%b want 0/0", bus4.busy, bus4.done); end
    tick();
    n_checks++; if (bus4.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got busy=%b want 1", bus4.busy); end
    bus4.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (bus4.done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got %b want 1", bus4.done); end
    n_checks++; if (bus4.d !== 4'b1110 || bus4.bo !== 1'b1) begin n_fail++; $display("FAIL b2b_second_result got d=%b bo=%b want 1110/1", bus4.d, bus4.bo); end
    tick();
  endtask

  task automatic test_width1();
    for (int i = 0; i < 8; i++) begin
      int   diff;
      logic exp_d;
      logic exp_bo;
      diff   = int'(i[2]) - int'(i[1]) - int'(i[0]);
      exp_d  = diff[0];
      exp_bo = (diff < 0);
      bus1.a = i[2]; bus1.b = i[1]; bus1.bi = i[0]; bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      n_checks++; if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin n_fail++; $display("FAIL w1_run vec %0d got busy=%b done=%b want 1/0", i, bus1.busy, bus1.done); end
      tick();
      n_checks++;
      if (bus1.done !== 1'b1 || bus1.d !== exp_d || bus1.bo !== exp_bo) begin
        n_fail++;
        $display("FAIL w1_result vec %0d got done=%b d=%b bo=%b want 1/%b/%b",
                 i, bus1.done, bus1.d, bus1.bo, exp_d, exp_bo);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_hold_ignore();
    test_reset_mid();
    test_back_to_back();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Bit-serial counterpart of the team's 4-bit ripple-carry adder. Computes d = a − b − bi, one bit per clock, LSB first.
- The borrow ripples through a registered full-subtractor cell instead of a chain of combinational cells.
- Used where area matters more than latency, and as the subtract path paired with the adder datapath.
- Start/busy/done handshake. Result and borrow-out are held until the next accepted start.

Parameters:
- WIDTH, 4, operand and result width in bits, legal range ≥1.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- bi  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- d  output  WIDTH  difference, (a − b − bi) mod 2^WIDTH.
- bo  output  1  borrow-out; 1 when a < b + bi (unsigned).

Behaviour:
- Reset: synchronous and active-high (rst sampled on the rising clk edge).
  - State goes to IDLE.
  - busy=0, done=0, d=0, bo=0.
  - Operand shift registers, bit counter and internal borrow are cleared.
  - rst overrides every other input, including mid-RUN; the partial result is discarded and no done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN:
  - Transition occurs on an edge where start=1.
  - That edge loads a and b into the shift registers, loads bi into the borrow register, and clears the bit counter.
  - busy=1 from the next cycle.
- RUN cell, one bit per edge, using operand LSBs ai and bi_:
  - diff = ai ^ bi_ ^ brw.
  - brw_next = (~ai & bi_) | (~(ai ^ bi_) & brw).
  - diff is shifted into the MSB of the result register, which shifts right.
  - The operand registers shift right.
  - The counter increments.
- RUN → DONE:
  - Transition occurs on the edge that processes bit WIDTH−1, i.e. the WIDTH-th RUN edge.
  - On that edge, d receives the full result and bo = brw_next.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0.
  - Then moves unconditionally to IDLE.
- Latency:
  - Accept edge at cycle 0; done is high during cycle WIDTH+1.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- d and bo:
  - Do not change during RUN; they show the previous result until the completing edge. This requires a separate working register.
  - Hold after DONE until the next completing edge or rst.
- start handling:
  - Ignored in RUN and DONE. It is not queued, and operand changes during RUN have no effect.
  - If start is held high continuously, a new operation is accepted on the first IDLE cycle after DONE.
- Counter width is clog2(WIDTH)+1; no wrap occurs in RUN.
- WIDTH=1: RUN lasts one edge; the cell output is the whole result.

Test Plan (WIDTH=4 unless noted):
- Basic subtract: a=1010, b=1001, bi=0 → busy for 4 cycles; done pulse in cycle 5 after the accept edge; d=0001, bo=0.
- Underflow: a=1000, b=1111, bi=0 → d=1001, bo=1. Then a=0000, b=0000, bi=1 → d=1111, bo=1.
- Hold and ignore:
  - Pulse start and change a/b every cycle during RUN → result still matches the captured operands.
  - Extra start pulses during RUN or DONE produce no additional done.
  - d/bo stable for ≥10 idle cycles afterward.
- Reset mid-op: assert rst on RUN edge 2 of 1111−0001 → next cycle busy=0, done=0, d=0, bo=0; no done follows. A fresh start then completes normally.
- Back-to-back: hold start=1 with 0101−0011 then 0011−0101 → first done gives d=0010, bo=0. Second accept occurs exactly one cycle after the first done; its done gives d=1110, bo=1.
- WIDTH=1 instance: all 8 (a,b,bi) combinations → d and bo match the full-subtractor truth table; done is 2 cycles after accept.
